// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared types and codes for the UART command packet parser
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      ST_SYNC,
      ST_CMD,
      ST_LEN,
      ST_PAYLOAD,
      ST_CHK
   } state_t;

   localparam logic [7:0] CMD_KEY  = 8'h01;
   localparam logic [7:0] CMD_MODE = 8'h02;
   localparam logic [7:0] CMD_DATA = 8'h03;
   localparam logic [7:0] CMD_END  = 8'h04;

   localparam logic [7:0] RSP_OK   = 8'h00;
   localparam logic [7:0] RSP_CHK  = 8'h01;
   localparam logic [7:0] RSP_BAD  = 8'h02;
   localparam logic [7:0] RSP_DROP = 8'h04;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // Unknown commands are never legal, whatever their length.
   function automatic logic len_ok(input logic [7:0] cmd, input logic [7:0] len);
      case (cmd)
         CMD_KEY:  return len == 8'd8;
         CMD_MODE: return len == 8'd1;
         CMD_DATA: return 1'b1;
         CMD_END:  return len == 8'd0;
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - frames UART bytes into checksummed command packets for the cipher core
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
   parameter int         TIMEOUT_CYCLES = 200000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        rx_parity_err,
   output logic [63:0] key_out,
   output logic        mode_out,
   output logic        key_en,
   output logic [7:0]  data_out,
   output logic        data_wr,
   input  logic        data_full,
   output logic        stream_end,
   output logic [7:0]  resp_data,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        err_overflow,
   output logic        err_frame
);

   localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t        state_q, state_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [7:0]    chk_q, chk_d;
   logic          bad_q, bad_d;
   logic          drop_q, drop_d;
   logic [63:0]   key_sh_q, key_sh_d;
   logic          mode_sh_q, mode_sh_d;
   logic [63:0]   key_q, key_d;
   logic          mode_q, mode_d;
   logic          key_en_q, key_en_d;
   logic [7:0]    data_q, data_d;
   logic          data_wr_q, data_wr_d;
   logic          stream_end_q, stream_end_d;
   logic [7:0]    resp_data_q, resp_data_d;
   logic          resp_valid_q, resp_valid_d;
   logic          err_ovf_q, err_ovf_d;
   logic          err_frame_q, err_frame_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          abort;
   logic          byte_ok;
   logic [7:0]    rsp;

   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      cnt_d        = cnt_q;
      chk_d        = chk_q;
      bad_d        = bad_q;
      drop_d       = drop_q;
      key_sh_d     = key_sh_q;
      mode_sh_d    = mode_sh_q;
      key_d        = key_q;
      mode_d       = mode_q;
      key_en_d     = 1'b0;
      data_d       = data_q;
      data_wr_d    = 1'b0;
      stream_end_d = stream_end_q;
      resp_data_d  = resp_data_q;
      resp_valid_d = resp_valid_q;
      err_ovf_d    = err_ovf_q;
      err_frame_d  = err_frame_q;
      tmo_d        = tmo_q;
      abort        = 1'b0;
      rsp          = RSP_OK;
      byte_ok      = rx_valid && !rx_parity_err;

      if (resp_valid_q && resp_ready) begin
         resp_valid_d = 1'b0;
      end

      // Inside a packet, a parity error or a silent line abandons the packet.
      if (state_q != ST_SYNC) begin
         if (rx_valid) begin
            tmo_d = '0;
         end else if (tmo_q == TMO_LAST) begin
            abort = 1'b1;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
         if (rx_parity_err) begin
            abort = 1'b1;
         end
      end

      if (abort) begin
         state_d     = ST_SYNC;
         tmo_d       = '0;
         err_frame_d = 1'b1;
      end else if (byte_ok) begin
         case (state_q)
            ST_SYNC: begin
               if (rx_data == SYNC_BYTE) begin
                  state_d = ST_CMD;
               end
            end
            ST_CMD: begin
               cmd_d   = rx_data;
               chk_d   = rx_data;
               bad_d   = 1'b0;
               drop_d  = 1'b0;
               state_d = ST_LEN;
            end
            ST_LEN: begin
               cnt_d   = rx_data;
               chk_d   = chk_q ^ rx_data;
               bad_d   = !len_ok(cmd_q, rx_data) || (cmd_q == CMD_DATA && stream_end_q);
               state_d = (rx_data != 8'd0) ? ST_PAYLOAD : ST_CHK;
            end
            ST_PAYLOAD: begin
               cnt_d = cnt_q - 8'd1;
               chk_d = chk_q ^ rx_data;
               if (cnt_q == 8'd1) begin
                  state_d = ST_CHK;
               end
               if (cmd_q == CMD_DATA) begin
                  if (data_full || stream_end_q) begin
                     drop_d    = 1'b1;
                     err_ovf_d = 1'b1;
                  end else begin
                     data_d    = rx_data;
                     data_wr_d = 1'b1;
                  end
               end else if (!bad_q && cmd_q == CMD_KEY) begin
                  key_sh_d = {key_sh_q[55:0], rx_data};
               end else if (!bad_q && cmd_q == CMD_MODE) begin
                  mode_sh_d = rx_data[0];
               end
            end
            ST_CHK: begin
               state_d = ST_SYNC;
               if (rx_data != chk_q) rsp = rsp | RSP_CHK;
               if (bad_q)            rsp = rsp | RSP_BAD;
               if (drop_q)           rsp = rsp | RSP_DROP;
               if (rsp == RSP_OK) begin
                  case (cmd_q)
                     CMD_KEY: begin
                        key_d    = key_sh_q;
                        key_en_d = 1'b1;
                     end
                     CMD_MODE: begin
                        mode_d   = mode_sh_q;
                        key_en_d = 1'b1;
                     end
                     CMD_END:  stream_end_d = 1'b1;
                     default:  ;
                  endcase
               end
               // An unread status is lost when the next one lands on top of it.
               if (resp_valid_q && !resp_ready) begin
                  err_ovf_d = 1'b1;
               end
               resp_data_d  = rsp;
               resp_valid_d = 1'b1;
            end
            default: state_d = ST_SYNC;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_SYNC;
         cmd_q        <= 8'h00;
         cnt_q        <= 8'h00;
         chk_q        <= 8'h00;
         bad_q        <= 1'b0;
         drop_q       <= 1'b0;
         key_sh_q     <= 64'h0;
         mode_sh_q    <= 1'b0;
         key_q        <= 64'h0;
         mode_q       <= 1'b0;
         key_en_q     <= 1'b0;
         data_q       <= 8'h00;
         data_wr_q    <= 1'b0;
         stream_end_q <= 1'b0;
         resp_data_q  <= 8'h00;
         resp_valid_q <= 1'b0;
         err_ovf_q    <= 1'b0;
         err_frame_q  <= 1'b0;
         tmo_q        <= '0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         cnt_q        <= cnt_d;
         chk_q        <= chk_d;
         bad_q        <= bad_d;
         drop_q       <= drop_d;
         key_sh_q     <= key_sh_d;
         mode_sh_q    <= mode_sh_d;
         key_q        <= key_d;
         mode_q       <= mode_d;
         key_en_q     <= key_en_d;
         data_q       <= data_d;
         data_wr_q    <= data_wr_d;
         stream_end_q <= stream_end_d;
         resp_data_q  <= resp_data_d;
         resp_valid_q <= resp_valid_d;
         err_ovf_q    <= err_ovf_d;
         err_frame_q  <= err_frame_d;
         tmo_q        <= tmo_d;
      end
   end

   assign key_out      = key_q;
   assign mode_out     = mode_q;
   assign key_en       = key_en_q;
   assign data_out     = data_q;
   assign data_wr      = data_wr_q;
   assign stream_end   = stream_end_q;
   assign resp_data    = resp_data_q;
   assign resp_valid   = resp_valid_q;
   assign err_overflow = err_ovf_q;
   assign err_frame    = err_frame_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - directed self-checking bench for uart_cmd_parser
module tb_uart_cmd_parser;

   localparam int TMO = 40;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_parity_err = 1'b0;
   logic [63:0] key_out;
   logic        mode_out;
   logic        key_en;
   logic [7:0]  data_out;
   logic        data_wr;
   logic        data_full = 1'b0;
   logic        stream_end;
   logic [7:0]  resp_data;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic        err_overflow;
   logic        err_frame;

   int errors = 0;
   int checks = 0;
   logic [7:0] wr_log[$];
   int key_en_cnt = 0;
   int resp_cnt = 0;

   uart_cmd_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_parity_err(rx_parity_err), .key_out(key_out), .mode_out(mode_out),
      .key_en(key_en), .data_out(data_out), .data_wr(data_wr), .data_full(data_full),
      .stream_end(stream_end), .resp_data(resp_data), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .err_overflow(err_overflow), .err_frame(err_frame)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (data_wr) wr_log.push_back(data_out);
      if (key_en) key_en_cnt++;
      if (resp_valid && resp_ready) resp_cnt++;
   end

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] bytes[$]);
      foreach (bytes[i]) send(bytes[i]);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [90:0] all_out;
      pulse_reset();
      all_out = {key_out, mode_out, key_en, data_out, data_wr, stream_end,
                 resp_data, resp_valid, err_overflow, err_frame};
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h required 0", all_out);
      end
   endtask

   task automatic test_key();
      send_pkt('{8'hA5, 8'h01, 8'h08, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h09});
      checks++;
      if (key_en !== 1'b1) begin errors++; $display("FAIL key_en_pulse: got %b required 1", key_en); end
      checks++;
      if (key_out !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL key_out: got %h required 0123456789abcdef", key_out); end
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 8'h00) begin
         errors++; $display("FAIL key_resp: got v=%b d=%h required v=1 d=00", resp_valid, resp_data);
      end
      @(negedge clk);
      checks++;
      if (key_en !== 1'b0 || resp_valid !== 1'b0) begin
         errors++; $display("FAIL key_en_one_cycle: got key_en=%b resp_valid=%b required 0 0", key_en, resp_valid);
      end
   endtask

   task automatic test_key_badchk_then_mode();
      send_pkt('{8'hA5, 8'h01, 8'h08, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h00});
      checks++;
      if (key_en !== 1'b0 || resp_data !== 8'h01 || resp_valid !== 1'b1) begin
         errors++; $display("FAIL badchk_resp: got key_en=%b v=%b d=%h required 0 1 01", key_en, resp_valid, resp_data);
      end
      send_pkt('{8'hA5, 8'h02, 8'h01, 8'h01, 8'h02});
      checks++;
      if (key_en !== 1'b1 || mode_out !== 1'b1 || key_out !== 64'h0123456789ABCDEF || resp_data !== 8'h00) begin
         errors++; $display("FAIL mode_commit: got key_en=%b mode=%b key=%h d=%h required 1 1 0123456789abcdef 00",
                            key_en, mode_out, key_out, resp_data);
      end
   endtask

   task automatic test_data();
      wr_log.delete();
      send(8'hA5); send(8'h03); send(8'h03); send(8'h10);
      checks++;
      if (data_wr !== 1'b1 || data_out !== 8'h10) begin
         errors++; $display("FAIL data_wr_timing: got wr=%b out=%h required 1 10", data_wr, data_out);
      end
      send(8'h20); send(8'h30); send(8'h00);
      checks++;
      if (resp_data !== 8'h00 || resp_valid !== 1'b1) begin
         errors++; $display("FAIL data_resp: got v=%b d=%h required 1 00", resp_valid, resp_data);
      end
      #1;
      checks++;
      if (wr_log.size() != 3 || wr_log[0] !== 8'h10 || wr_log[1] !== 8'h20 || wr_log[2] !== 8'h30) begin
         errors++; $display("FAIL data_bytes: got %p required 10 20 30", wr_log);
      end
      wr_log.delete();
      @(negedge clk);
      send(8'hA5); send(8'h03); send(8'h03); send(8'h10);
      data_full = 1'b1;
      send(8'h20);
      data_full = 1'b0;
      send(8'h30); send(8'h00);
      checks++;
      if (resp_data !== 8'h04 || err_overflow !== 1'b1) begin
         errors++; $display("FAIL drop_resp: got d=%h ovf=%b required 04 1", resp_data, err_overflow);
      end
      #1;
      checks++;
      if (wr_log.size() != 2 || wr_log[0] !== 8'h10 || wr_log[1] !== 8'h30) begin
         errors++; $display("FAIL drop_bytes: got %p required 10 30", wr_log);
      end
   endtask

   task automatic test_timeout_then_end();
      logic saw_resp;
      @(negedge clk);
      wr_log.delete();
      saw_resp = 1'b0;
      send_pkt('{8'hA5, 8'h03, 8'h02, 8'h11});
      for (int i = 0; i < TMO - 1; i++) begin
         @(negedge clk);
         if (resp_valid) saw_resp = 1'b1;
      end
      checks++;
      if (err_frame !== 1'b0) begin errors++; $display("FAIL timeout_early: got err_frame=%b required 0", err_frame); end
      @(negedge clk);
      checks++;
      if (err_frame !== 1'b1 || saw_resp !== 1'b0) begin
         errors++; $display("FAIL timeout_abort: got err_frame=%b resp_seen=%b required 1 0", err_frame, saw_resp);
      end
      #1;
      checks++;
      if (wr_log.size() != 1 || wr_log[0] !== 8'h11) begin
         errors++; $display("FAIL timeout_forwarded: got %p required 11", wr_log);
      end
      @(negedge clk);
      send_pkt('{8'hA5, 8'h04, 8'h00, 8'h04});
      checks++;
      if (stream_end !== 1'b1 || resp_data !== 8'h00 || resp_valid !== 1'b1) begin
         errors++; $display("FAIL end_pkt: got end=%b v=%b d=%h required 1 1 00", stream_end, resp_valid, resp_data);
      end
      wr_log.delete();
      send_pkt('{8'hA5, 8'h03, 8'h01, 8'h55, 8'h57});
      #1;
      checks++;
      if (resp_data !== 8'h06 || wr_log.size() != 0) begin
         errors++; $display("FAIL data_after_end: got d=%h writes=%0d required 06 0", resp_data, wr_log.size());
      end
   endtask

   task automatic test_bad_cmd();
      int ke;
      @(negedge clk);
      ke = key_en_cnt;
      send_pkt('{8'hA5, 8'h07, 8'h00, 8'h07});
      checks++;
      if (resp_data !== 8'h02 || resp_valid !== 1'b1) begin
         errors++; $display("FAIL unknown_cmd: got v=%b d=%h required 1 02", resp_valid, resp_data);
      end
      send_pkt('{8'hA5, 8'h01, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h41});
      checks++;
      if (resp_data !== 8'h02 || resp_valid !== 1'b1 || key_out !== 64'h0123456789ABCDEF) begin
         errors++; $display("FAIL key_badlen: got v=%b d=%h key=%h required 1 02 0123456789abcdef",
                            resp_valid, resp_data, key_out);
      end
      @(negedge clk);
      #1;
      checks++;
      if (key_en_cnt != ke) begin errors++; $display("FAIL bad_no_key_en: got %0d pulses required 0", key_en_cnt - ke); end
   endtask

   task automatic test_parity_and_reset();
      logic [90:0] all_out;
      int rc;
      rc = resp_cnt;
      send_pkt('{8'hA5, 8'h03, 8'h05, 8'h01, 8'h02});
      rx_parity_err = 1'b1;
      send(8'h03);
      rx_parity_err = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (err_frame !== 1'b1 || resp_cnt != rc || resp_valid !== 1'b0) begin
         errors++; $display("FAIL parity_abort: got err_frame=%b resps=%0d required 1 0", err_frame, resp_cnt - rc);
      end
      @(negedge clk);
      send_pkt('{8'hA5, 8'h01, 8'h08, 8'h01, 8'h02});
      pulse_reset();
      all_out = {key_out, mode_out, key_en, data_out, data_wr, stream_end,
                 resp_data, resp_valid, err_overflow, err_frame};
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL midpkt_reset: got %h required 0", all_out); end
      rx_parity_err = 1'b1;
      @(negedge clk);
      rx_parity_err = 1'b0;
      send_pkt('{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08});
      checks++;
      if (err_frame !== 1'b0 || resp_valid !== 1'b0 || key_en !== 1'b0) begin
         errors++; $display("FAIL sync_ignore: got err_frame=%b v=%b key_en=%b required 0 0 0", err_frame, resp_valid, key_en);
      end
   endtask

   task automatic test_back_to_back_overwrite();
      resp_ready = 1'b0;
      send_pkt('{8'hA5, 8'h02, 8'h01, 8'h01, 8'h02});
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 8'h00 || err_overflow !== 1'b0 || mode_out !== 1'b1 || key_out !== 64'h0) begin
         errors++; $display("FAIL b2b_first: got v=%b d=%h ovf=%b mode=%b key=%h required 1 00 0 1 0",
                            resp_valid, resp_data, err_overflow, mode_out, key_out);
      end
      send_pkt('{8'hA5, 8'h07, 8'h00, 8'h07});
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 8'h02 || err_overflow !== 1'b1) begin
         errors++; $display("FAIL resp_overwrite: got v=%b d=%h ovf=%b required 1 02 1", resp_valid, resp_data, err_overflow);
      end
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1) begin errors++; $display("FAIL resp_hold: got %b required 1", resp_valid); end
      resp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL resp_accept: got %b required 0", resp_valid); end
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      test_reset();
      test_key();
      test_key_badchk_then_mode();
      test_data();
      test_timeout_then_end();
      test_bad_cmd();
      test_parity_and_reset();
      test_back_to_back_overwrite();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Packet parser between the UART receiver and the bhargava core in the 200 MHz domain. Frames raw received bytes into checksummed command packets: key load, mode select, stream data and end-of-stream. Drives the core's key/mode/key_en, mpeg write and stream_end inputs, and returns one status byte per packet toward the UART transmitter.

## Interface
Parameters:
- SYNC_BYTE, 8'hA5: packet start marker.
- TIMEOUT_CYCLES, 200000: maximum idle clocks between bytes inside a packet (1 ms at 200 MHz).

Ports:
- clk  in  1  system clock (clk_200 domain).
- rst  in  1  reset; one clock, synchronous, active-high.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- rx_parity_err  in  1  one-cycle strobe; the current byte is corrupt.
- key_out  out  64  committed DES key.
- mode_out  out  1  committed mode (0 encrypt, 1 decrypt).
- key_en  out  1  one-cycle pulse when key_out/mode_out are committed.
- data_out  out  8  stream byte to the core.
- data_wr  out  1  write strobe for data_out.
- data_full  in  1  core input FIFO full.
- stream_end  out  1  sticky end-of-stream.
- resp_data  out  8  status byte.
- resp_valid  out  1  status pending.
- resp_ready  in  1  transmitter accepts status.
- err_overflow  out  1  sticky; a data byte was dropped.
- err_frame  out  1  sticky; a packet was aborted (parity error or timeout).

## Operation
- Packet format: SYNC_BYTE, CMD, LEN, LEN payload bytes, CHK.
- CHK is the XOR of CMD, LEN and all payload bytes.
- Commands:
  - 0x01 KEY: LEN must be 8. The first payload byte goes to key[63:56].
  - 0x02 MODE: LEN must be 1. Only bit 0 is used.
  - 0x03 DATA: LEN 0..255.
  - 0x04 END: LEN must be 0.
- FSM states: SYNC, CMD, LEN, PAYLOAD, CHK. Transitions occur only on rx_valid.
  - SYNC: advance to CMD on SYNC_BYTE; ignore any other byte.
  - CMD: latch the command and go to LEN.
  - LEN: latch the length. Set bad_cmd if the command is unknown or LEN is illegal for it. Go to PAYLOAD if LEN≠0, otherwise CHK.
  - PAYLOAD: decrement the remaining count; go to CHK when the last byte arrives.
  - CHK: compare, then return to SYNC.
- Illegal packets are consumed in full so framing is kept. They have no side effects.
- KEY and MODE payloads fill shadow registers. On a good CHK the shadows copy to key_out/mode_out and key_en pulses.
  - MODE alone also pulses key_en, with the existing key.
- DATA payload bytes are forwarded as they arrive, before the checksum is known.
  - If data_full is high on the byte's rx_valid cycle, or stream_end is set: no data_wr, the byte is dropped, and err_overflow is set.
- END with a good CHK sets stream_end.
- Response byte, issued after every completed packet:
  - 0x00: ok.
  - 0x01: checksum mismatch.
  - 0x02: bad command/length, or DATA after stream_end.
  - 0x04: a byte was dropped within this packet.
  - Codes OR together.
- Response register:
  - resp_valid holds until resp_ready.
  - If a new response is due while one is still pending, the new one overwrites it and err_overflow is set.
- Abort rules:
  - rx_parity_err in any state other than SYNC, or TIMEOUT_CYCLES clocks without rx_valid outside SYNC: return to SYNC, set err_frame, send no response, commit nothing.
  - rx_parity_err in SYNC is ignored.
  - Bytes already forwarded are not retracted.
- rx_valid and rx_parity_err together: the error wins and the byte is discarded.

## Timing
- Reset values:
  - All outputs 0; key_out 64'h0.
  - FSM in SYNC; shadows and timeout counter cleared.
  - Sticky flags clear only on rst.
- A reset in mid-packet discards the partial packet and gives no response.
- data_wr and data_out are registered: asserted the cycle after the payload byte's rx_valid, for exactly one cycle.
- key_en is asserted the cycle after the CHK byte's rx_valid. key_out and mode_out update on that same cycle.
- resp_valid rises the cycle after the CHK byte's rx_valid. The transfer completes on a cycle with resp_valid and resp_ready both high; resp_valid is low the next cycle unless overwritten.
- Timeout counter:
  - Counts while the state is not SYNC; clears on every rx_valid.
  - Its width is $clog2(TIMEOUT_CYCLES+1).
  - The abort takes effect on the cycle the count reaches TIMEOUT_CYCLES.
- The payload down-counter is 8 bits; LEN=255 gives 255 payload bytes.
- Back-to-back packets with no gap are supported.

## Structure
- Package uart_cmd_pkg holds:
  - state enum (SYNC, CMD, LEN, PAYLOAD, CHK);
  - command codes CMD_KEY/CMD_MODE/CMD_DATA/CMD_END;
  - response codes RSP_OK/RSP_CHK/RSP_BAD/RSP_DROP;
  - default SYNC_BYTE.
- No sub-module. FSM, counters and shadow registers sit in one module.

## Test plan
- KEY packet A5 01 08 01 23 45 67 89 AB CD EF CHK=0x09 -> key_out=64'h0123456789ABCDEF, key_en high for 1 cycle, resp 0x00.
- Same KEY packet with CHK=0x00 -> key_out unchanged, no key_en, resp 0x01. Then MODE A5 02 01 01 CHK=0x02 -> mode_out=1, key_en pulse, resp 0x00.
- DATA A5 03 03 10 20 30 CHK=0x00, data_full low -> three data_wr pulses carrying 10,20,30, resp 0x00. Repeat with data_full high during 0x20 -> 10,30 written, resp 0x04, err_overflow=1.
- A5 03 02 11, then TIMEOUT_CYCLES idle clocks -> FSM back in SYNC, err_frame=1, no resp. Then a valid END A5 04 00 04 -> stream_end=1, resp 0x00.
- A5 07 00 07 -> resp 0x02. A KEY packet with LEN=4 -> payload consumed, resp 0x02, no key_en.
- rx_parity_err mid-payload, then rst asserted mid-packet -> all outputs and sticky flags at 0, FSM in SYNC.
